// File: rtl/sdr_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sdr_mem_responder
//  Purpose  : SDRAM device-side responder. Decodes SDR commands, tracks open
//             rows per bank, stores write data and returns CAS-delayed reads.
//  Revision : 1.0
// ============================================================================
module sdr_mem_responder #(
    parameter int SDR_DW = 16,
    parameter int SDR_BW = 2,
    parameter int RW     = 4,
    parameter int CW     = 8
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              sdr_cke,
    input  logic              sdr_cs_n,
    input  logic              sdr_ras_n,
    input  logic              sdr_cas_n,
    input  logic              sdr_we_n,
    input  logic [SDR_BW-1:0] sdr_dqm,
    input  logic [1:0]        sdr_ba,
    input  logic [12:0]       sdr_addr,
    input  logic [SDR_DW-1:0] sdr_dq_i,
    output logic [SDR_DW-1:0] sdr_dq_o,
    output logic [SDR_BW-1:0] sdr_dq_oe,
    output logic [12:0]       mode_reg,
    output logic              err_cmd,
    output logic [15:0]       rfsh_cnt
);

    localparam int AW    = 2 + RW + CW;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        BST_IDLE = 2'd0,
        BST_RD   = 2'd1,
        BST_WR   = 2'd2
    } burst_t;

    typedef enum logic {
        BK_IDLE = 1'b0,
        BK_OPEN = 1'b1
    } bank_t;

    logic [12:0]       r_mode;
    logic              r_err;
    logic [15:0]       r_rfsh;
    bank_t             r_bank_st  [4];
    logic [RW-1:0]     r_bank_row [4];

    burst_t            r_bst;
    burst_t            w_bst_nxt;
    logic [1:0]        r_bba;
    logic [RW-1:0]     r_brow;
    logic [CW-1:0]     r_bcol;
    logic [2:0]        r_blm1;
    logic [2:0]        r_beat;
    logic              r_bap;

    logic [SDR_DW-1:0] r_mem [DEPTH];
    logic [2:0]        r_pv;
    logic [AW-1:0]     r_pa [3];
    logic [SDR_BW-1:0] r_dqm1;
    logic [SDR_BW-1:0] r_dqm2;
    logic [SDR_DW-1:0] r_dq_o;
    logic [SDR_BW-1:0] r_dq_oe;

    logic [2:0]        w_cmd;
    logic              w_dec;
    logic              w_mrs, w_ref, w_pre, w_act, w_wr, w_rd, w_bt;
    logic              w_any_open;
    logic              w_tgt_open;
    logic              w_cl_bad;
    logic              w_new_rw;
    logic              w_err_ev;
    logic              w_stop;
    logic [2:0]        w_blm1;
    logic              w_cl2;

    logic              w_iss;
    logic              w_iss_rd;
    logic [1:0]        w_iss_ba;
    logic [RW-1:0]     w_iss_row;
    logic [CW-1:0]     w_iss_base;
    logic [2:0]        w_iss_beat;
    logic [2:0]        w_iss_blm1;
    logic              w_ap_close;
    logic [CW-1:0]     w_mask;
    logic [CW-1:0]     w_iss_col;
    logic [AW-1:0]     w_iss_addr;
    logic              w_rd_iss;
    logic              w_mem_we;
    logic              w_flush;

    assign w_cmd = {sdr_ras_n, sdr_cas_n, sdr_we_n};
    assign w_dec = sdr_cke & ~sdr_cs_n;
    assign w_mrs = w_dec & (w_cmd == 3'b000);
    assign w_ref = w_dec & (w_cmd == 3'b001);
    assign w_pre = w_dec & (w_cmd == 3'b010);
    assign w_act = w_dec & (w_cmd == 3'b011);
    assign w_wr  = w_dec & (w_cmd == 3'b100);
    assign w_rd  = w_dec & (w_cmd == 3'b101);
    assign w_bt  = w_dec & (w_cmd == 3'b110);

    always_comb begin
        w_any_open = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (r_bank_st[b] == BK_OPEN) w_any_open = 1'b1;
        end
    end

    assign w_tgt_open = (r_bank_st[sdr_ba] == BK_OPEN);
    assign w_cl_bad   = (sdr_addr[6:4] != 3'd2) && (sdr_addr[6:4] != 3'd3);
    assign w_new_rw   = (w_rd | w_wr) & w_tgt_open;
    assign w_err_ev   = (w_mrs & (w_any_open | w_cl_bad)) | (w_act & w_tgt_open)
                      | ((w_rd | w_wr) & ~w_tgt_open) | (w_ref & w_any_open);
    assign w_stop     = w_bt | (w_pre & (sdr_addr[10] | (sdr_ba == r_bba)));

    always_comb begin
        case (r_mode[2:0])
            3'd1:    w_blm1 = 3'd1;
            3'd2:    w_blm1 = 3'd3;
            3'd3:    w_blm1 = 3'd7;
            default: w_blm1 = 3'd0;
        endcase
    end
    // Illegal CL codes fall back to CL3.
    assign w_cl2 = (r_mode[6:4] == 3'd2);

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_mode <= 13'h030;
            r_err  <= 1'b0;
            r_rfsh <= 16'd0;
        end else begin
            if (w_err_ev)               r_err  <= 1'b1;
            if (w_mrs && !w_any_open)   r_mode <= sdr_addr;
            if (w_ref && !w_any_open)   r_rfsh <= r_rfsh + 16'd1;
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            for (int b = 0; b < 4; b++) begin
                r_bank_st[b]  <= BK_IDLE;
                r_bank_row[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w_pre && (sdr_addr[10] || (sdr_ba == 2'(b)))) begin
                    r_bank_st[b] <= BK_IDLE;
                end else if (w_act && (sdr_ba == 2'(b)) && (r_bank_st[b] == BK_IDLE)) begin
                    r_bank_st[b]  <= BK_OPEN;
                    r_bank_row[b] <= sdr_addr[RW-1:0];
                end
                if (w_ap_close && (w_iss_ba == 2'(b))) r_bank_st[b] <= BK_IDLE;
            end
        end
    end

    // A new READ/WRITE pre-empts the running burst and issues its beat 0 at once;
    // a stop request still issues the beat due on that edge.
    always_comb begin
        w_bst_nxt  = r_bst;
        w_iss      = 1'b0;
        w_iss_rd   = 1'b0;
        w_iss_ba   = r_bba;
        w_iss_row  = r_brow;
        w_iss_base = r_bcol;
        w_iss_beat = r_beat;
        w_iss_blm1 = r_blm1;
        w_ap_close = 1'b0;
        if (w_new_rw) begin
            w_iss      = 1'b1;
            w_iss_rd   = w_rd;
            w_iss_ba   = sdr_ba;
            w_iss_row  = r_bank_row[sdr_ba];
            w_iss_base = sdr_addr[CW-1:0];
            w_iss_beat = 3'd0;
            w_iss_blm1 = w_blm1;
            if (w_blm1 == 3'd0) begin
                w_bst_nxt  = BST_IDLE;
                w_ap_close = sdr_addr[10];
            end else begin
                w_bst_nxt = w_rd ? BST_RD : BST_WR;
            end
        end else if (sdr_cke && (r_bst != BST_IDLE)) begin
            w_iss    = 1'b1;
            w_iss_rd = (r_bst == BST_RD);
            if (r_beat == r_blm1) begin
                w_bst_nxt  = BST_IDLE;
                w_ap_close = r_bap;
            end else if (w_stop) begin
                w_bst_nxt = BST_IDLE;
            end
        end
    end

    assign w_mask     = CW'(w_iss_blm1);
    assign w_iss_col  = (w_iss_base & ~w_mask) | ((w_iss_base + CW'(w_iss_beat)) & w_mask);
    assign w_iss_addr = {w_iss_ba, w_iss_row, w_iss_col};
    assign w_rd_iss   = w_iss & w_iss_rd;
    assign w_mem_we   = w_iss & ~w_iss_rd;
    assign w_flush    = w_new_rw & w_wr;

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_bst <= BST_IDLE;
        end else begin
            r_bst <= w_bst_nxt;
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_bba  <= 2'd0;
            r_brow <= '0;
            r_bcol <= '0;
            r_blm1 <= 3'd0;
            r_beat <= 3'd0;
            r_bap  <= 1'b0;
        end else if (w_new_rw) begin
            r_bba  <= sdr_ba;
            r_brow <= r_bank_row[sdr_ba];
            r_bcol <= sdr_addr[CW-1:0];
            r_blm1 <= w_blm1;
            r_bap  <= sdr_addr[10];
            r_beat <= 3'd1;
        end else if (w_iss) begin
            r_beat <= r_beat + 3'd1;
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < SDR_BW; b++) begin
                if (!sdr_dqm[b]) r_mem[w_iss_addr][8*b +: 8] <= sdr_dq_i[8*b +: 8];
            end
        end
    end

    // CL2 reads enter one stage later so stage 2 always feeds the output register;
    // the RAM is read at output time, so a same-edge write is already visible.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_pv    <= 3'b000;
            for (int s = 0; s < 3; s++) r_pa[s] <= '0;
            r_dqm1  <= '0;
            r_dqm2  <= '0;
            r_dq_o  <= '0;
            r_dq_oe <= '0;
        end else if (sdr_cke) begin
            r_dqm1  <= sdr_dqm;
            r_dqm2  <= r_dqm1;
            r_pa[0] <= w_iss_addr;
            r_pa[1] <= (w_rd_iss && w_cl2) ? w_iss_addr : r_pa[0];
            r_pa[2] <= r_pa[1];
            if (w_flush) begin
                r_pv    <= 3'b000;
                r_dq_oe <= '0;
            end else begin
                r_pv[0] <= w_rd_iss & ~w_cl2;
                r_pv[1] <= r_pv[0] | (w_rd_iss & w_cl2);
                r_pv[2] <= r_pv[1];
                if (r_pv[2]) begin
                    r_dq_o  <= r_mem[r_pa[2]];
                    r_dq_oe <= ~r_dqm2;
                end else begin
                    r_dq_oe <= '0;
                end
            end
        end
    end

    assign sdr_dq_o  = r_dq_o;
    assign sdr_dq_oe = r_dq_oe;
    assign mode_reg  = r_mode;
    assign err_cmd   = r_err;
    assign rfsh_cnt  = r_rfsh;

endmodule
`default_nettype wire
